nv_fifo_ctrl_128x11: RTL and testbench
======================================

# nv_fifo_ctrl_128x11

Read/write controller that turns a 128x11 single-clock two-port RAM (registered read address, registered output-enable data stage) into a valid/ready FIFO. It owns the write and read pointers, drives the RAM write port from an upstream handshake, and drives the RAM `ra`/`re`/`ore` read pipeline so that the RAM's `dout` register is the FIFO output register. The block sits between an NVDLA producer and consumer wherever a 128-deep, 11-bit elastic buffer is needed. It delivers back-to-back throughput with no skid buffer.

## Interface
Parameters:
- `DEPTH`, 128: RAM entries; power of two.
- `WIDTH`, 11: data width.
- `AW`, 7: log2(DEPTH).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `in_vld`  in  1  upstream word valid.
- `in_rdy`  out  1  space available.
- `in_data`  in  WIDTH  upstream word.
- `out_vld`  out  1  output word valid.
- `out_rdy`  in  1  downstream accepts.
- `out_data`  out  WIDTH  equals `ram_dout`.
- `ram_wa`  out  AW  RAM write address.
- `ram_we`  out  1  RAM write enable.
- `ram_di`  out  WIDTH  RAM write data.
- `ram_ra`  out  AW  RAM read address.
- `ram_re`  out  1  RAM read-address capture enable.
- `ram_ore`  out  1  RAM output-register enable.
- `ram_dout`  in  WIDTH  RAM registered output.
- `occupancy`  out  AW+1  words held, counting RAM contents and in-flight reads.
- `hwm`  out  AW+1  high-water mark; present only with the macro.

## Operation
- Push: `push = in_vld & in_rdy`. Drive `ram_we = push`, `ram_wa = wr_ptr`, `ram_di = in_data`. `wr_ptr` (AW+1 bits, with a wrap bit) increments on push.
- Unread count: `avail = wr_ptr - rd_ptr` (AW+1 bits). `rd_ptr` increments on `ram_re`.
- Read pipeline valid bits:
  - `v1`: the RAM address register holds an issued address.
  - `v2`: the RAM output register holds data.
- `pop = out_vld & out_rdy`; `out_vld = v2`.
- `ram_ore = v1 & (~v2 | pop)`.
- `ram_re = (avail != 0) & (~v1 | ram_ore)`; `ram_ra = rd_ptr[AW-1:0]`.
- Valid-bit updates:
  - `v1` next = `ram_re | (v1 & ~ram_ore)`.
  - `v2` next = `ram_ore | (v2 & ~pop)`.
- When `ram_re` is low, the RAM holds its read address. When `ram_ore` is low, it holds its output. A stalled downstream therefore freezes both stages without data loss.
- `occupancy = avail + v1 + v2`.
- `in_rdy = (occupancy < DEPTH)`. `in_rdy` does not depend on same-cycle `pop`; this keeps the path registered-only.
- Simultaneous push and pop: `occupancy` is unchanged.
- Simultaneous push and `ram_re` with `avail == 0`: not possible, because `avail` is registered. The new word is read no earlier than the next cycle.
- Pointer wrap: address bits wrap 127→0, and the wrap bit toggles. Full is `occupancy == 128`, never pointer equality.
- `out_data` is undefined when `out_vld = 0`.

## Timing
- Reset values: `in_rdy = 1`, `out_vld = 0`, `occupancy = 0`, `hwm = 0`.
- Reset values: `ram_we = ram_re = ram_ore = 0`, `ram_wa = ram_ra = 0`.
- Reset values: pointers 0, `v1 = v2 = 0`.
- Empty-FIFO latency, with push in cycle 0:
  - `ram_re` in cycle 1.
  - `ram_ore` in cycle 2.
  - `out_vld` in cycle 3.
- Steady state: one word per cycle in and out.
- Reset asserted mid-operation discards all contents and in-flight reads immediately. RAM contents are not cleared.
- `out_vld` stays high and `out_data` stays stable until `pop`.

## Configuration
- `NV_FIFO_CTRL_HWM_EN` defined:
  - Adds the `hwm` port and register.
  - `hwm` updates to `max(hwm, occupancy)` each cycle and resets to 0.
- Not defined:
  - No `hwm` port or register.
  - All other behaviour is identical.

## Structure
- Shared package holds `NV_FIFO128_DEPTH`, `NV_FIFO128_AW`, `NV_FIFO128_WIDTH`, and the pointer typedef (AW+1 bits).
- One natural sub-module: `nv_fifo_ctrl_rd_pipe`, containing `v1`/`v2`, the `ram_re`/`ram_ore`/`out_vld` logic, and `rd_ptr`.
- Pointers, occupancy and the HWM logic stay in the top level.
- The bench instantiates the RAM model beside the controller.

## Test plan
- Reset, then push 0x001..0x005 on consecutive cycles with `out_rdy = 1`:
  - `out_vld` first rises in cycle 3.
  - `out_data` is 0x001..0x005 on consecutive cycles.
  - `occupancy` returns to 0.
- Push 128 words with `out_rdy = 0`:
  - `in_rdy` falls after the 128th push, with `occupancy = 128`.
  - A 129th `in_vld` is not accepted.
- From full, set `out_rdy = 1` and keep `in_vld = 1`:
  - Throughput is one word per cycle.
  - Order is preserved across the 127→0 wrap.
  - Data 0x7FF survives.
- Random `out_rdy` stalls (50%) with continuous push of an incrementing pattern:
  - No drop, duplicate or reorder.
  - `out_data` is stable while stalled.
- Assert `rst` while `v1 = v2 = 1` and `occupancy = 40`:
  - All outputs return to reset values in the same cycle.
  - After release, a push of 0x2AA emerges after 3 cycles.
- With `NV_FIFO_CTRL_HWM_EN`, push 50, pop 30, push 20:
  - `hwm = 50`, then 50, then 50.
  - After 40 further pushes (total 80), `hwm = 80`.

Source files
------------

// File: rtl/nv_fifo_ctrl_128x11_pkg.sv
// Shared constants and pointer type for the 128x11 FIFO controller.
package nv_fifo_ctrl_128x11_pkg;

    localparam int NV_FIFO128_DEPTH = 128;
    localparam int NV_FIFO128_AW    = 7;
    localparam int NV_FIFO128_WIDTH = 11;

    // Read/write pointer: address bits plus one wrap bit.
    typedef logic [NV_FIFO128_AW:0] nv_fifo128_ptr_t;

endpackage : nv_fifo_ctrl_128x11_pkg

// File: rtl/nv_fifo_ctrl_rd_pipe.sv
// Read-side pipeline for the 128x11 FIFO: steers the RAM read-address and
// output-register stages and owns the read pointer.
module nv_fifo_ctrl_rd_pipe #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW:0]   avail_i,
    input  logic          out_rdy_i,
    output logic          out_vld_o,
    output logic          ram_re_o,
    output logic          ram_ore_o,
    output logic [AW-1:0] ram_ra_o,
    output logic [AW:0]   rd_ptr_o,
    output logic          v1_o,
    output logic          v2_o
);

    logic        v1_q;
    logic        v1_d;
    logic        v2_q;
    logic        v2_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    logic        pop_s;
    logic        ore_s;
    logic        re_s;

    // Stage advance: each stage moves only when the one after it can take
    // the word, so a stalled consumer freezes both RAM registers in place.
    always_comb begin
        pop_s    = v2_q & out_rdy_i;
        ore_s    = v1_q & (~v2_q | pop_s);
        re_s     = (avail_i != {(AW+1){1'b0}}) & (~v1_q | ore_s);
        v1_d     = re_s | (v1_q & ~ore_s);
        v2_d     = ore_s | (v2_q & ~pop_s);
        rd_ptr_d = rd_ptr_q;
        if (re_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Read pointer and stage valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign out_vld_o = v2_q;
    assign ram_re_o  = re_s;
    assign ram_ore_o = ore_s;
    assign ram_ra_o  = rd_ptr_q[AW-1:0];
    assign rd_ptr_o  = rd_ptr_q;
    assign v1_o      = v1_q;
    assign v2_o      = v2_q;

endmodule : nv_fifo_ctrl_rd_pipe

// File: rtl/nv_fifo_ctrl_128x11.sv
// Valid/ready FIFO controller around a 128x11 two-port RAM whose dout register
// is the FIFO output. Define NV_FIFO_CTRL_HWM_EN to add the high-water mark.
module nv_fifo_ctrl_128x11
    import nv_fifo_ctrl_128x11_pkg::*;
#(
    parameter int DEPTH = NV_FIFO128_DEPTH,
    parameter int WIDTH = NV_FIFO128_WIDTH,
    parameter int AW    = NV_FIFO128_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    ram_wa,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_di,
    output logic [AW-1:0]    ram_ra,
    output logic             ram_re,
    output logic             ram_ore,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [AW:0]      occupancy
`ifdef NV_FIFO_CTRL_HWM_EN
    ,
    output logic [AW:0]      hwm
`endif
);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_s;
    logic [AW:0] avail_s;
    logic [AW:0] occupancy_s;
    logic        in_rdy_s;
    logic        push_s;
    logic        v1_s;
    logic        v2_s;

    nv_fifo_ctrl_rd_pipe #(
        .AW (AW)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .avail_i   (avail_s),
        .out_rdy_i (out_rdy),
        .out_vld_o (out_vld),
        .ram_re_o  (ram_re),
        .ram_ore_o (ram_ore),
        .ram_ra_o  (ram_ra),
        .rd_ptr_o  (rd_ptr_s),
        .v1_o      (v1_s),
        .v2_o      (v2_s)
    );

    // Fill level counts words still in the RAM plus those already in the read
    // stages; full is decided on this count, never on pointer equality.
    always_comb begin
        avail_s     = wr_ptr_q - rd_ptr_s;
        occupancy_s = avail_s + (AW+1)'(v1_s) + (AW+1)'(v2_s);
        in_rdy_s    = (occupancy_s < (AW+1)'(DEPTH));
        push_s      = in_vld & in_rdy_s;
        wr_ptr_d    = wr_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Write pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign in_rdy    = in_rdy_s;
    assign ram_we    = push_s;
    assign ram_wa    = wr_ptr_q[AW-1:0];
    assign ram_di    = in_data;
    assign out_data  = ram_dout;
    assign occupancy = occupancy_s;

`ifdef NV_FIFO_CTRL_HWM_EN
    logic [AW:0] hwm_q;
    logic [AW:0] hwm_d;

    // Running maximum of the fill level.
    always_comb begin
        hwm_d = hwm_q;
        if (occupancy_s > hwm_q) begin
            hwm_d = occupancy_s;
        end else begin
            hwm_d = hwm_q;
        end
    end

    // High-water mark register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_q <= {(AW+1){1'b0}};
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule : nv_fifo_ctrl_128x11

// File: tb/tb_nv_fifo_ctrl_128x11.sv
// Directed bench for nv_fifo_ctrl_128x11 with a behavioural 128x11 RAM beside it.
module tb_nv_fifo_ctrl_128x11;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [10:0] in_data;
    logic        out_vld;
    logic        out_rdy;
    logic [10:0] out_data;
    logic [6:0]  ram_wa;
    logic        ram_we;
    logic [10:0] ram_di;
    logic [6:0]  ram_ra;
    logic        ram_re;
    logic        ram_ore;
    logic [10:0] ram_dout;
    logic [7:0]  occupancy;
`ifdef NV_FIFO_CTRL_HWM_EN
    logic [7:0]  hwm;
`endif

    int tests = 0;
    int fails = 0;
    logic [10:0] exp_q[$];

    nv_fifo_ctrl_128x11 dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .ram_wa    (ram_wa),
        .ram_we    (ram_we),
        .ram_di    (ram_di),
        .ram_ra    (ram_ra),
        .ram_re    (ram_re),
        .ram_ore   (ram_ore),
        .ram_dout  (ram_dout),
        .occupancy (occupancy)
`ifdef NV_FIFO_CTRL_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    // RAM model: registered read address, registered output-enable data stage.
    logic [10:0] mem [0:127];
    logic [6:0]  ra_q;
    logic [10:0] dout_q;
    always @(posedge clk) begin
        if (ram_we)  mem[ram_wa] <= ram_di;
        if (ram_re)  ra_q <= ram_ra;
        if (ram_ore) dout_q <= mem[ra_q];
    end
    assign ram_dout = dout_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; in_data = 11'h000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests++; if (in_rdy !== 1'b1)    begin fails++; $display("FAIL reset_in_rdy: got %0b want 1", in_rdy); end
        tests++; if (out_vld !== 1'b0)   begin fails++; $display("FAIL reset_out_vld: got %0b want 0", out_vld); end
        tests++; if (occupancy !== 8'd0) begin fails++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        tests++; if ({ram_we, ram_re, ram_ore} !== 3'b000) begin fails++; $display("FAIL reset_ram_ctl: got %b want 000", {ram_we, ram_re, ram_ore}); end
        tests++; if ({ram_wa, ram_ra} !== 14'd0) begin fails++; $display("FAIL reset_ram_addr: got wa=%0d ra=%0d want 0", ram_wa, ram_ra); end
`ifdef NV_FIFO_CTRL_HWM_EN
        tests++; if (hwm !== 8'd0) begin fails++; $display("FAIL reset_hwm: got %0d want 0", hwm); end
`endif
        @(negedge clk);
    endtask

    task automatic test_latency_basic();
        for (int k = 0; k < 9; k++) begin
            out_rdy = 1'b1;
            if (k < 5) begin in_vld = 1'b1; in_data = 11'(k + 1); end
            else begin in_vld = 1'b0; end
            #1;
            if (k == 0) begin
                tests++; if ({ram_we, ram_wa, ram_di} !== {1'b1, 7'd0, 11'h001}) begin fails++; $display("FAIL basic_wport: got we=%0b wa=%0d di=%0h want 1/0/001", ram_we, ram_wa, ram_di); end
            end
            if (k == 1) begin
                tests++; if (ram_re !== 1'b1) begin fails++; $display("FAIL basic_re_c1: got %0b want 1", ram_re); end
            end
            if (k == 2) begin
                tests++; if (ram_ore !== 1'b1) begin fails++; $display("FAIL basic_ore_c2: got %0b want 1", ram_ore); end
            end
            tests++; if (out_vld !== (k >= 3 && k <= 7)) begin fails++; $display("FAIL basic_vld_c%0d: got %0b want %0b", k, out_vld, (k >= 3 && k <= 7)); end
            if (k >= 3 && k <= 7) begin
                tests++; if (out_data !== 11'(k - 2)) begin fails++; $display("FAIL basic_data_c%0d: got %0h want %0h", k, out_data, k - 2); end
            end
            @(negedge clk);
        end
        #1;
        tests++; if (occupancy !== 8'd0) begin fails++; $display("FAIL basic_occ_end: got %0d want 0", occupancy); end
        @(negedge clk);
    endtask

    task automatic test_fill();
        exp_q.delete();
        out_rdy = 1'b0;
        for (int i = 0; i < 128; i++) begin
            in_vld = 1'b1;
            in_data = (i == 127) ? 11'h7FF : 11'(11'h400 + i);
            #1;
            tests++; if (in_rdy !== 1'b1 || occupancy !== 8'(i)) begin fails++; $display("FAIL fill_%0d: got rdy=%0b occ=%0d want 1/%0d", i, in_rdy, occupancy, i); end
            exp_q.push_back(in_data);
            @(negedge clk);
        end
        in_vld = 1'b1; in_data = 11'h123;
        #1;
        tests++; if (in_rdy !== 1'b0)      begin fails++; $display("FAIL full_in_rdy: got %0b want 0", in_rdy); end
        tests++; if (occupancy !== 8'd128) begin fails++; $display("FAIL full_occ: got %0d want 128", occupancy); end
        tests++; if (ram_we !== 1'b0)      begin fails++; $display("FAIL full_no_we: got %0b want 0", ram_we); end
        tests++; if (out_vld !== 1'b1 || out_data !== 11'h400) begin fails++; $display("FAIL full_head: got vld=%0b data=%0h want 1/400", out_vld, out_data); end
        @(negedge clk);
        #1;
        tests++; if (occupancy !== 8'd128) begin fails++; $display("FAIL full_129th: got occ=%0d want 128", occupancy); end
        @(negedge clk);
    endtask

    task automatic test_drain_wrap();
        logic [10:0] nxt;
        logic        seen_7ff;
        logic        rdy_now;
        nxt = 11'h500;
        seen_7ff = 1'b0;
        for (int c = 0; c < 130; c++) begin
            out_rdy = 1'b1; in_vld = 1'b1; in_data = nxt;
            #1;
            rdy_now = in_rdy;
            tests++; if (out_vld !== 1'b1) begin fails++; $display("FAIL drain_tput_c%0d: got vld=%0b want 1", c, out_vld); end
            tests++; if (out_data !== exp_q[0]) begin fails++; $display("FAIL drain_order_c%0d: got %0h want %0h", c, out_data, exp_q[0]); end
            tests++; if (rdy_now !== (c != 0)) begin fails++; $display("FAIL drain_in_rdy_c%0d: got %0b want %0b", c, rdy_now, (c != 0)); end
            if (out_data === 11'h7FF && exp_q[0] === 11'h7FF) seen_7ff = 1'b1;
            if (rdy_now) begin exp_q.push_back(nxt); nxt = nxt + 11'd1; end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        tests++; if (seen_7ff !== 1'b1) begin fails++; $display("FAIL drain_7ff: got seen=%0b want 1", seen_7ff); end
        in_vld = 1'b0; out_rdy = 1'b1;
        for (int b = 0; b < 300 && exp_q.size() > 0; b++) begin
            #1;
            if (out_vld) begin
                tests++; if (out_data !== exp_q[0]) begin fails++; $display("FAIL drain_tail: got %0h want %0h", out_data, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        #1;
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL drain_timeout: got %0d left want 0", exp_q.size()); end
        tests++; if (occupancy !== 8'd0 || out_vld !== 1'b0) begin fails++; $display("FAIL drain_empty: got occ=%0d vld=%0b want 0/0", occupancy, out_vld); end
        @(negedge clk);
    endtask

    task automatic test_random_stall();
        logic [10:0] nxt;
        logic        prev_stall;
        logic [10:0] prev_data;
        exp_q.delete();
        nxt = 11'h000;
        prev_stall = 1'b0;
        prev_data = 11'h000;
        for (int c = 0; c < 200; c++) begin
            out_rdy = 1'($urandom_range(0, 1));
            in_vld = 1'b1; in_data = nxt;
            #1;
            if (prev_stall) begin
                tests++; if (out_vld !== 1'b1 || out_data !== prev_data) begin fails++; $display("FAIL stall_hold_c%0d: got vld=%0b data=%0h want 1/%0h", c, out_vld, out_data, prev_data); end
            end
            if (out_vld) begin
                tests++;
                if (exp_q.size() == 0) begin fails++; $display("FAIL stall_dup_c%0d: got %0h want no word", c, out_data); end
                else if (out_data !== exp_q[0]) begin fails++; $display("FAIL stall_order_c%0d: got %0h want %0h", c, out_data, exp_q[0]); end
            end
            if (in_rdy) begin exp_q.push_back(nxt); nxt = nxt + 11'd1; end
            if (out_vld && out_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
            prev_stall = out_vld & ~out_rdy;
            prev_data = out_data;
            @(negedge clk);
        end
        in_vld = 1'b0; out_rdy = 1'b1;
        for (int b = 0; b < 300 && exp_q.size() > 0; b++) begin
            #1;
            if (out_vld) begin
                tests++; if (out_data !== exp_q[0]) begin fails++; $display("FAIL stall_tail: got %0h want %0h", out_data, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        #1;
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL stall_drop: got %0d undelivered want 0", exp_q.size()); end
        tests++; if (occupancy !== 8'd0) begin fails++; $display("FAIL stall_occ_end: got %0d want 0", occupancy); end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        out_rdy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_vld = 1'b1; in_data = 11'(11'h600 + i);
            @(negedge clk);
        end
        in_vld = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (occupancy !== 8'd40 || out_vld !== 1'b1) begin fails++; $display("FAIL midop_pre: got occ=%0d vld=%0b want 40/1", occupancy, out_vld); end
        tests++; if ({ram_re, ram_ore} !== 2'b00) begin fails++; $display("FAIL midop_frozen: got re/ore=%b want 00", {ram_re, ram_ore}); end
        rst = 1'b1;
        #1;
        tests++; if (in_rdy !== 1'b1 || out_vld !== 1'b0 || occupancy !== 8'd0) begin fails++; $display("FAIL midop_rst_out: got rdy=%0b vld=%0b occ=%0d want 1/0/0", in_rdy, out_vld, occupancy); end
        tests++; if ({ram_we, ram_re, ram_ore, ram_wa, ram_ra} !== 17'd0) begin fails++; $display("FAIL midop_rst_ram: got we=%0b re=%0b ore=%0b wa=%0d ra=%0d want 0", ram_we, ram_re, ram_ore, ram_wa, ram_ra); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            out_rdy = 1'b1;
            if (k == 0) begin in_vld = 1'b1; in_data = 11'h2AA; end
            else begin in_vld = 1'b0; end
            #1;
            tests++; if (out_vld !== (k == 3)) begin fails++; $display("FAIL midop_lat_c%0d: got vld=%0b want %0b", k, out_vld, (k == 3)); end
            if (k == 3) begin
                tests++; if (out_data !== 11'h2AA) begin fails++; $display("FAIL midop_data: got %0h want 2aa", out_data); end
            end
            @(negedge clk);
        end
    endtask

`ifdef NV_FIFO_CTRL_HWM_EN
    task automatic test_hwm();
        int pops;
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin in_vld = 1'b1; in_data = 11'(i); @(negedge clk); end
        in_vld = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (hwm !== 8'd50) begin fails++; $display("FAIL hwm_push50: got %0d want 50", hwm); end
        pops = 0;
        for (int b = 0; b < 100 && pops < 30; b++) begin
            out_rdy = 1'b1;
            #1;
            if (out_vld) pops++;
            @(negedge clk);
        end
        out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (hwm !== 8'd50 || occupancy !== 8'd20) begin fails++; $display("FAIL hwm_pop30: got hwm=%0d occ=%0d want 50/20", hwm, occupancy); end
        for (int i = 0; i < 20; i++) begin in_vld = 1'b1; in_data = 11'(i); @(negedge clk); end
        in_vld = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (hwm !== 8'd50) begin fails++; $display("FAIL hwm_push20: got %0d want 50", hwm); end
        for (int i = 0; i < 40; i++) begin in_vld = 1'b1; in_data = 11'(i); @(negedge clk); end
        in_vld = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (hwm !== 8'd80 || occupancy !== 8'd80) begin fails++; $display("FAIL hwm_push40: got hwm=%0d occ=%0d want 80/80", hwm, occupancy); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_latency_basic();
        test_fill();
        test_drain_wrap();
        test_random_stall();
        test_reset_midop();
`ifdef NV_FIFO_CTRL_HWM_EN
        test_hwm();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_nv_fifo_ctrl_128x11
